// File: rtl/update_arbiter.sv
// update_arbiter: round-robin, per-frame quota-limited serializer of requester records
// onto one registered valid/ready stream, with sticky overrun flags at tick boundaries.
module update_arbiter #(
    parameter int N     = 3,
    parameter int RW    = 81,
    parameter int QUOTA = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N-1:0]    req_valid,
    input  logic [N*RW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic            out_valid,
    output logic [RW-1:0]   out_data,
    output logic [1:0]      out_src,
    input  logic            out_ready,
    output logic [N-1:0]    overrun,
    output logic [7:0]      frame_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t       state;
    logic         tick_q, tick_evt, free, gnt;
    logic [1:0]   ptr, win, cand;
    logic [N-1:0] elig;
    logic [3:0]   quota_cnt [N];

    assign tick_evt  = tick ^ tick_q;
    assign free      = state == EMPTY || out_ready;
    assign out_valid = state == FULL;
    assign req_ready = gnt ? N'(1) << win : '0;

    always_comb
        for (int i = 0; i < N; i++)
            elig[i] = rst && req_valid[i] && free && (quota_cnt[i] < 4'(QUOTA) || tick_evt);

    // scan from the farthest candidate back so the one right after ptr wins
    always_comb begin
        gnt  = 1'b0;
        win  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = 2'((int'(ptr) + k) % N);
            if (elig[cand]) begin
                gnt = 1'b1;
                win = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= 2'(N - 1);
            tick_q    <= 1'b0;
            overrun   <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < N; i++) quota_cnt[i] <= '0;
        end else begin
            tick_q <= tick;
            if (tick_evt) overrun <= overrun | (req_valid & ~req_ready);
            for (int i = 0; i < N; i++)
                if (gnt && win == 2'(i)) quota_cnt[i] <= tick_evt ? 4'd1 : quota_cnt[i] + 4'd1;
                else if (tick_evt) quota_cnt[i] <= '0;
            if (gnt) begin
                state    <= FULL;
                out_data <= req_data[int'(win)*RW +: RW];
                out_src  <= win;
                ptr      <= win;
            end else if (out_ready) begin
                state <= EMPTY;
            end
            frame_cnt <= tick_evt ? {7'd0, gnt} : frame_cnt + {7'd0, gnt && frame_cnt != 8'hFF};
        end
    end
endmodule

// File: tb/tb_update_arbiter.sv
// tb_update_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a frame/quota/round-robin model of the arbiter.
module tb_update_arbiter;
    localparam int N = 3, RW = 81, QUOTA = 4;

    logic clk = 0, rst = 0, tick = 0, out_ready = 0;
    logic [N-1:0]    req_valid = '0;
    logic [RW-1:0]   rd [N];
    logic [N*RW-1:0] req_data;
    logic [N-1:0]    req_ready, overrun;
    logic            out_valid;
    logic [RW-1:0]   out_data;
    logic [1:0]      out_src;
    logic [7:0]      frame_cnt;

    int tests = 0, fails = 0;

    bit            m_valid;
    logic [RW-1:0] m_data;
    int            m_src, m_ptr, m_frame, last_w, g;
    int            m_q [N];
    logic [N-1:0]  m_over, exp_ready;
    logic          m_tickq;
    logic [RW-1:0] saved;

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < N; i++) req_data[i*RW +: RW] = rd[i];

    update_arbiter #(.N(N), .RW(RW), .QUOTA(QUOTA)) dut (
        .clk(clk), .rst(rst), .tick(tick), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rnd();
        return RW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic m_reset();
        m_valid = 0; m_data = '0; m_src = 0; m_ptr = N - 1; m_frame = 0;
        m_over = '0; m_tickq = 0; last_w = -1;
        foreach (m_q[i]) m_q[i] = 0;
    endtask

    // winner = first valid requester after the last winner that still has quota left
    function automatic int pick();
        bit evt = tick != m_tickq;
        if (!rst || !(!m_valid || out_ready)) return -1;
        for (int k = 1; k <= N; k++) begin
            int i = (m_ptr + k) % N;
            if (req_valid[i] && (m_q[i] < QUOTA || evt)) return i;
        end
        return -1;
    endfunction

    task automatic cycle();
        int w;
        bit evt;
        @(negedge clk);
        w = pick();
        exp_ready = w >= 0 ? N'(1) << w : '0;
        chk("req_ready", req_ready, exp_ready);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
        chk("overrun", overrun, m_over);
        chk("frame_cnt", frame_cnt, m_frame);
        @(posedge clk);
        if (!rst) m_reset();
        else begin
            evt = tick != m_tickq;
            m_tickq = tick;
            if (evt) begin
                m_over |= req_valid & ~exp_ready;
                m_frame = 0;
                foreach (m_q[i]) m_q[i] = 0;
            end
            if (w >= 0) begin
                m_data = rd[w]; m_src = w; m_valid = 1; m_ptr = w; m_q[w]++;
                if (m_frame < 255) m_frame++;
            end else if (out_ready) m_valid = 0;
            last_w = w;
        end
        #1;
    endtask

    task automatic hold_refresh();
        if (last_w >= 0) rd[last_w] = rnd();
    endtask

    task automatic pulse_rst();
        rst = 0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        rst = 1;
        m_reset();
    endtask

    initial begin
        m_reset();
        foreach (rd[i]) rd[i] = rnd();
        req_valid = '1; out_ready = 1; tick = 1;
        repeat (3) cycle();
        req_valid = '0; tick = 0; out_ready = 0;
        rst = 1;
        #1;
        chk("idle_valid", out_valid, 0);
        chk("idle_frame", frame_cnt, 0);
        chk("idle_overrun", overrun, 0);
        chk("idle_ready", req_ready, 0);
        chk("idle_data", out_data, 0);
        cycle();

        req_valid = 3'b001; rd[0] = 81'h1ABC; out_ready = 1;
        #1 chk("single_ready", req_ready, 3'b001);
        cycle();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 81'h1ABC);
        chk("single_src", out_src, 0);
        chk("single_frame", frame_cnt, 1);
        req_valid = '0;
        cycle();

        pulse_rst();
        req_valid = '1;
        foreach (rd[i]) rd[i] = rnd();
        for (int j = 0; j < 4; j++) begin
            cycle();
            chk("rr_src", out_src, j % 3);
            if (j == 3) saved = rd[0];
            hold_refresh();
        end
        out_ready = 0;
        repeat (3) begin
            #1 chk("bp_ready", req_ready, 0);
            cycle();
            chk("bp_hold", out_data, saved);
        end
        out_ready = 1;
        cycle();
        chk("bp_resume_src", out_src, 1);
        hold_refresh();
        req_valid = '0;
        cycle();

        pulse_rst();
        req_valid = 3'b100;
        g = 0;
        repeat (6) begin
            #1 g += int'(req_ready[2]);
            cycle();
            hold_refresh();
        end
        chk("quota_grants", g, 4);
        #1 chk("quota_block", req_ready, 0);
        tick = 1;
        #1 chk("quota_tick_ready", req_ready, 3'b100);
        cycle();
        chk("quota_tick_frame", frame_cnt, 1);
        hold_refresh();
        g = 1;
        repeat (5) begin
            #1 g += int'(req_ready[2]);
            cycle();
            hold_refresh();
        end
        chk("quota_after_tick", g, 4);
        req_valid = '0;
        cycle();

        tick = 0;
        pulse_rst();
        req_valid = 3'b011; out_ready = 0;
        cycle();
        hold_refresh();
        cycle();
        tick = 1;
        cycle();
        chk("overrun_set", overrun, 3'b011);
        out_ready = 1;
        repeat (4) begin
            cycle();
            hold_refresh();
        end
        req_valid = '0;
        cycle();
        chk("overrun_sticky", overrun, 3'b011);

        req_valid = 3'b010; out_ready = 0;
        cycle();
        chk("mid_full", out_valid, 1);
        pulse_rst();
        req_valid = '1; out_ready = 1;
        #1 chk("mid_first_grant", req_ready, 3'b001);
        cycle();
        hold_refresh();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (last_w == i || !req_valid[i]) begin
                    req_valid[i] = $urandom_range(0, 99) < 60;
                    rd[i] = rnd();
                end
            out_ready = $urandom_range(0, 99) < 70;
            if ($urandom_range(0, 99) < 4) tick = ~tick;
            if ($urandom_range(0, 999) < 3) pulse_rst();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/update_arbiter.md
# update_arbiter

Shares the single host-update channel between the component control units: Airflow, Thrusters and Solar Panel. The arbiter sits between those control units and the stdout update writer. Each unit offers packed update records ("update_float" / "update_extra" payloads). The arbiter serializes them round-robin into one registered valid/ready stream. It enforces a per-tick record quota per unit and flags units that still have a record pending when the next server tick arrives.

## Interface
- N, default 3: number of requesters; legal 1..4, because the component id is 2 bits.
- RW, default 81: record width. Records are opaque to this block; the requester packs kind, id, selector, width and 64-bit float.
- QUOTA, default 4: maximum records accepted per requester per tick frame; legal 1..15.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  server tick level. It toggles once per server tick and is synchronous to clk.
- req_valid  in  N  requester i has a record.
- req_data  in  N*RW  record of requester i, at bits [i*RW +: RW].
- req_ready  out  N  one-hot or zero; record of requester i accepted this cycle.
- out_valid  out  1  output record valid.
- out_data  out  RW  output record.
- out_src  out  2  index of the requester that produced out_data.
- out_ready  in  1  update writer accepts out_data.
- overrun  out  N  sticky per requester; a record was pending at a frame boundary.
- frame_cnt  out  8  records accepted in the current frame, saturating at 255.

## Operation
- **Tick event.**
  - tick_q registers tick.
  - tick_evt = tick ^ tick_q, a one-cycle pulse that starts a new frame.
- **Output slot states.**
  - One-entry output register with two states.
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - free = EMPTY | (FULL & out_ready).
- **Eligibility.** Requester i is eligible when:
  - req_valid[i]=1,
  - quota_cnt[i] < QUOTA, or tick_evt=1 this cycle (the fresh frame quota applies immediately),
  - free=1.
- **Grant.**
  - Round-robin search starts at ptr+1 mod N.
  - The first eligible requester wins and gets req_ready[win]=1, combinationally in the same cycle.
  - All other req_ready bits are 0.
  - With no eligible requester, req_ready=0.
- **On a grant (record transfer):**
  - out_data <= req_data[win], out_src <= win, state FULL.
  - ptr <= win.
  - quota_cnt[win] increments. If tick_evt is also high, quota_cnt[win] <= 1 and all others <= 0.
- **FULL with out_ready=1 and no grant:** state EMPTY, out_data holds its value.
- **FULL with out_ready=0:** out_data, out_src and out_valid hold; req_ready=0.
- **On tick_evt:**
  - All quota_cnt clear to 0 (except the same-cycle grant rule above).
  - frame_cnt <= 0, or 1 if a grant occurs in that cycle.
  - overrun[i] sets for every i with req_valid[i]=1 and req_ready[i]=0 in that cycle.
  - overrun is cleared only by rst.
- **frame_cnt** increments on every grant and saturates at 255.
- **Reset (rst=0, asynchronous):**
  - out_valid=0, out_data=0, out_src=0, req_ready=0, overrun=0, frame_cnt=0.
  - state EMPTY, all quota_cnt=0, tick_q=0.
  - ptr=N-1, so requester 0 has first priority.
  - Asserting reset mid-transfer drops the held record.
  - If tick=1 at the first clk edge after reset release, a tick_evt occurs in that cycle.

## Timing
- Request to output latency: 1 cycle. A record accepted at edge k appears with out_valid=1 after edge k.
- Throughput: 1 record per cycle while out_ready=1 (back-to-back grants through the FULL & out_ready path).
- req_ready depends combinationally on req_valid, out_ready and tick; there is no other combinational path to outputs.
- Requesters must hold req_valid and req_data stable until req_ready=1.
- **Simultaneous events:**
  - tick_evt, grant and output drain in one cycle are all honoured.
  - The overrun check excludes the requester granted in that cycle.
- **Fairness:** with all N requesters continuously valid and out_ready=1, the grant order is 0,1,2,0,1,2,… and each requester gets exactly QUOTA grants per frame if the frame is long enough.

## Test plan
- **Reset/idle.** Hold rst=0 with random inputs, then release with all req_valid=0 → all outputs 0, frame_cnt=0.
- **Single requester latency.** req_valid=001, data 0x1ABC, out_ready=1 → req_ready=001 in cycle 0; out_valid=1, out_data=0x1ABC, out_src=0 in cycle 1; frame_cnt=1.
- **Round-robin and backpressure.** All valid, out_ready=1 → out_src sequence 0,1,2,0. Then out_ready=0 for 3 cycles → out_data held and req_ready=000. Then out_ready=1 → resumes with src 1.
- **Quota.** QUOTA=4, only requester 2 valid, no tick → exactly 4 grants, then req_ready=000. Toggle tick → grant in the same cycle, quota_cnt[2]=1, frame_cnt=1.
- **Overrun.** Requesters 0 and 1 valid, out_ready=0. Toggle tick → overrun=011, and it stays 011 after both are later served.
- **Reset mid-transfer.** Set FULL with out_ready=0, then pulse rst low between clock edges → out_valid falls immediately (asynchronously); ptr restarts, so the first grant goes to requester 0.
